rs_slot_tracker: RTL and testbench
==================================

Name: rs_slot_tracker

Overview:
Owns the reservation-station occupancy bitmap (free_status, 1 = slot free) that feeds the free-tag lookup.
- Consumes the lookup's chosen tag on dispatch: allocate handshake, clears the free bit.
- Returns slots on issue/completion: release ports, set the free bit.
- Supports pipeline flush.
- One instance per station: ALU and LS.

Parameters:
RS_SIZE, 6, number of station slots; width of free_status.
TAG_W, 3, slot tag width; must satisfy 2^TAG_W > RS_SIZE.
NO_FREE_TAG, 3'b111, sentinel tag meaning "no free slot", taken from the shared package.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  reset; asynchronous, active-high.
flush  in  1  synchronous clear: all slots free.
alloc_valid  in  1  dispatch wants a slot this cycle.
alloc_tag  in  TAG_W  tag proposed by the free-tag lookup.
alloc_grant  out  1  combinational; allocation accepted this cycle.
rel0_valid  in  1  release port 0 (issue path).
rel0_tag  in  TAG_W  slot released on port 0.
rel1_valid  in  1  release port 1 (completion/cancel path).
rel1_tag  in  TAG_W  slot released on port 1.
free_status  out  RS_SIZE  registered bitmap; bit i = 1 means slot i is free.
free_count  out  TAG_W  registered number of free slots, 0..RS_SIZE.
full  out  1  registered; free_status == 0.
err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, any time, including mid-operation):
  - free_status = all ones; free_count = RS_SIZE; full = 0; err = 0.
  - alloc_grant goes low immediately.
- alloc_grant = alloc_valid & !flush & alloc_tag != NO_FREE_TAG & alloc_tag < RS_SIZE & free_status[alloc_tag].
  - Pure function of inputs and current state.
  - Zero-cycle handshake; a granted slot is busy from the next edge.
- Rejected alloc (bad tag, tag busy, or full): no state change, no err. Dispatch stalls and retries.
- Release port k legal when rel_k_valid & rel_k_tag < RS_SIZE & !free_status[rel_k_tag]. Free bit set at next edge.
- Release errors (err set next edge; the release is ignored):
  - rel_k_tag >= RS_SIZE, or the slot is already free.
  - Both ports valid with the same tag: slot freed once, counted once, err set.
- Alloc and release on the same tag in the same cycle: mutually exclusive by the legality rules. If the slot is free, alloc is granted and the release is flagged as error.
- Alloc of slot A plus legal releases of B and C in the same cycle: all three take effect. free_count_next = free_count - grant + legal release count (0..2).
- flush: highest priority after rst.
  - Next state: all free, free_count = RS_SIZE, full = 0.
  - alloc_grant forced 0; releases in the flush cycle ignored, no err from them.
  - err not cleared by flush.
- err is cleared only by rst.
- Invariants, checked by the bench every cycle:
  - free_count == popcount(free_status).
  - full == (free_count == 0).
  - Bits at index >= RS_SIZE do not exist.
- No wrap-around: free_count never exceeds RS_SIZE or goes below 0 under any input sequence.
- Latency: status, count, and full update one cycle after the triggering event. No internal state machine beyond the bitmap, counter, and err.

Decomposition:
- Shared package holds RS_SIZE_ALU = 6, RS_SIZE_LS = 6, TAG_W = 3, NO_FREE_TAG = 3'b111, and the tag type. The same constants are used by the free-tag lookup.
- Sub-module tag_onehot: TAG_W tag plus valid in, RS_SIZE one-hot plus in_range out. Instantiated three times: alloc, rel0, rel1.
- Next-state masks and count arithmetic stay in rs_slot_tracker.

Test Plan:
1. Reset then 6 back-to-back allocs with tags 0,1,2,3,4,5 (lowest-free order) -> grants all 1. free_status steps 111110, 111100, ..., 000000. free_count 5..0. full = 1 after the 6th. 7th alloc with NO_FREE_TAG -> grant 0, err 0.
2. free_status 000000; rel0 tag 2 and rel1 tag 4 together -> next free_status 010100, free_count 2, full 0, err 0.
3. free_status 010100; alloc tag 2 plus rel0 tag 0 plus rel1 tag 5 -> grant 1, next free_status 110001, free_count 3.
4. Error cases, each from a clean state:
   - rel0 of free slot 3 -> err = 1, status unchanged.
   - rel0 = rel1 = tag 1 (slot busy) -> bit 1 set once, count +1, err = 1.
   - rel1 tag 6 -> ignored, err = 1.
5. Busy slots with alloc_valid and rel0 asserted in the same cycle as flush -> grant 0; next free_status 111111, count 6; err keeps its prior value.
6. Async rst asserted mid-cycle with slots busy and err = 1 -> outputs return to 111111 / 6 / 0 / 0 without a clock edge. Operation resumes on the first edge after deassertion.

Source files
------------

// File: rtl/rs_slot_tracker_pkg.sv
// Shared reservation-station constants and tag type.
// Also used by the free-tag lookup.
package rs_slot_tracker_pkg;

  localparam int RS_SIZE_ALU = 6;
  localparam int RS_SIZE_LS  = 6;
  localparam int TAG_W       = 3;

  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t NO_FREE_TAG = 3'b111;

endpackage

// File: rtl/rs_slot_tracker_tag_onehot.sv
// Decodes a slot tag into a one-hot slot mask.
// Out-of-range tags decode to an empty mask.
module tag_onehot
  import rs_slot_tracker_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_ALU
) (
  input  logic               valid_i,
  input  tag_t               tag_i,
  output logic [RS_SIZE-1:0] onehot_o,
  output logic               in_range_o
);

  assign in_range_o = {{(32-TAG_W){1'b0}}, tag_i} < RS_SIZE;

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      onehot_o[i] = valid_i && (tag_i == TAG_W'(i));
    end
  end

endmodule

// File: rtl/rs_slot_tracker.sv
// Reservation-station occupancy bitmap with one alloc
// port, two release ports, flush and a sticky error flag.
module rs_slot_tracker
  import rs_slot_tracker_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_ALU
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc_valid,
  input  tag_t               alloc_tag,
  output logic               alloc_grant,
  input  logic               rel0_valid,
  input  tag_t               rel0_tag,
  input  logic               rel1_valid,
  input  tag_t               rel1_tag,
  output logic [RS_SIZE-1:0] free_status,
  output logic [TAG_W-1:0]   free_count,
  output logic               full,
  output logic               err
);

  localparam logic [RS_SIZE-1:0] ALL_FREE = {RS_SIZE{1'b1}};

  logic [RS_SIZE-1:0] free_q, free_d;
  logic [TAG_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               err_q, err_d;

  logic [RS_SIZE-1:0] alloc_oh, rel0_oh, rel1_oh;
  logic               alloc_rng, rel0_rng, rel1_rng;
  logic               rel0_ok, rel1_ok, dup;
  logic               rel_err;

  tag_onehot #(.RS_SIZE(RS_SIZE)) u_alloc_dec (
    .valid_i    (alloc_valid),
    .tag_i      (alloc_tag),
    .onehot_o   (alloc_oh),
    .in_range_o (alloc_rng)
  );

  tag_onehot #(.RS_SIZE(RS_SIZE)) u_rel0_dec (
    .valid_i    (rel0_valid),
    .tag_i      (rel0_tag),
    .onehot_o   (rel0_oh),
    .in_range_o (rel0_rng)
  );

  tag_onehot #(.RS_SIZE(RS_SIZE)) u_rel1_dec (
    .valid_i    (rel1_valid),
    .tag_i      (rel1_tag),
    .onehot_o   (rel1_oh),
    .in_range_o (rel1_rng)
  );

  assign alloc_grant = !rst && alloc_valid && !flush
                    && alloc_rng
                    && (alloc_tag != NO_FREE_TAG)
                    && |(alloc_oh & free_q);

  // A duplicate tag on port 1 is the error; port 0 frees it.
  assign dup = rel0_valid && rel1_valid
            && (rel0_tag == rel1_tag);

  assign rel0_ok = rel0_rng && |(rel0_oh & ~free_q);
  assign rel1_ok = rel1_rng && |(rel1_oh & ~free_q) && !dup;

  assign rel_err = (rel0_valid && !rel0_ok)
                || (rel1_valid && !rel1_ok);

  always_comb begin
    free_d  = free_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush) begin
      free_d  = ALL_FREE;
      count_d = TAG_W'(RS_SIZE);
    end else begin
      free_d = free_q
             & ~(alloc_grant ? alloc_oh : '0)
             | (rel0_ok ? rel0_oh : '0)
             | (rel1_ok ? rel1_oh : '0);
      count_d = count_q
              - TAG_W'(alloc_grant)
              + TAG_W'(rel0_ok)
              + TAG_W'(rel1_ok);
      err_d = err_q || rel_err;
    end
    full_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q  <= ALL_FREE;
      count_q <= TAG_W'(RS_SIZE);
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      free_q  <= free_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign free_status = free_q;
  assign free_count  = count_q;
  assign full        = full_q;
  assign err         = err_q;

endmodule

// File: tb/tb_rs_slot_tracker.sv
// Directed bench for rs_slot_tracker with immediate
// assertions and a per-cycle invariant monitor.
module tb_rs_slot_tracker;
  import rs_slot_tracker_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       alloc_valid;
  tag_t       alloc_tag;
  logic       alloc_grant;
  logic       rel0_valid;
  tag_t       rel0_tag;
  logic       rel1_valid;
  tag_t       rel1_tag;
  logic [5:0] free_status;
  logic [2:0] free_count;
  logic       full;
  logic       err;

  int total = 0;
  int bad   = 0;

  rs_slot_tracker #(.RS_SIZE(RS_SIZE_ALU)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .alloc_grant (alloc_grant),
    .rel0_valid  (rel0_valid),
    .rel0_tag    (rel0_tag),
    .rel1_valid  (rel1_valid),
    .rel1_tag    (rel1_tag),
    .free_status (free_status),
    .free_count  (free_count),
    .full        (full),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic av, input tag_t at,
                       input logic r0v, input tag_t r0t,
                       input logic r1v, input tag_t r1t,
                       input logic fl);
    alloc_valid = av;
    alloc_tag   = at;
    rel0_valid  = r0v;
    rel0_tag    = r0t;
    rel1_valid  = r1v;
    rel1_tag    = r1t;
    flush       = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic state(input string tag,
                       input logic [5:0] fs,
                       input int cnt,
                       input logic fu,
                       input logic er);
    chk({tag, ".free"}, 32'(free_status), 32'(fs));
    chk({tag, ".cnt"},  32'(free_count),  32'(cnt));
    chk({tag, ".full"}, 32'(full),        32'(fu));
    chk({tag, ".err"},  32'(err),         32'(er));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Invariants sampled on the opposite edge each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv.popcnt", 32'(free_count),
          32'($countones(free_status)));
      chk("inv.full", 32'(full), 32'(free_count == 3'd0));
    end
  end

  initial begin
    rst = 1'b1;
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 0);
    chk("rst.grant", 32'(alloc_grant), 32'd0);
    tick();
    state("rst", 6'b111111, 6, 0, 0);
    rst = 1'b0;
    idle();

    // 1: fill all six slots in order
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 0);
    chk("a0.grant", 32'(alloc_grant), 32'd1);
    tick(); state("a0", 6'b111110, 5, 0, 0);
    drive(1, 3'd1, 0, 3'd0, 0, 3'd0, 0);
    chk("a1.grant", 32'(alloc_grant), 32'd1);
    tick(); state("a1", 6'b111100, 4, 0, 0);
    drive(1, 3'd2, 0, 3'd0, 0, 3'd0, 0);
    chk("a2.grant", 32'(alloc_grant), 32'd1);
    tick(); state("a2", 6'b111000, 3, 0, 0);
    drive(1, 3'd3, 0, 3'd0, 0, 3'd0, 0);
    chk("a3.grant", 32'(alloc_grant), 32'd1);
    tick(); state("a3", 6'b110000, 2, 0, 0);
    drive(1, 3'd4, 0, 3'd0, 0, 3'd0, 0);
    chk("a4.grant", 32'(alloc_grant), 32'd1);
    tick(); state("a4", 6'b100000, 1, 0, 0);
    drive(1, 3'd5, 0, 3'd0, 0, 3'd0, 0);
    chk("a5.grant", 32'(alloc_grant), 32'd1);
    tick(); state("a5", 6'b000000, 0, 1, 0);
    drive(1, 3'd7, 0, 3'd0, 0, 3'd0, 0);
    chk("a7.grant", 32'(alloc_grant), 32'd0);
    tick(); state("a7", 6'b000000, 0, 1, 0);
    drive(1, 3'd3, 0, 3'd0, 0, 3'd0, 0);
    chk("busy.grant", 32'(alloc_grant), 32'd0);
    tick(); state("busy", 6'b000000, 0, 1, 0);

    // 2: dual release from full
    drive(0, 3'd0, 1, 3'd2, 1, 3'd4, 0);
    tick(); state("rel24", 6'b010100, 2, 0, 0);

    // 3: alloc plus two releases
    drive(1, 3'd2, 1, 3'd0, 1, 3'd5, 0);
    chk("mix.grant", 32'(alloc_grant), 32'd1);
    tick(); state("mix", 6'b110001, 3, 0, 0);

    // 4a: release of a free slot
    do_reset();
    drive(0, 3'd0, 1, 3'd3, 0, 3'd0, 0);
    tick(); state("relfree", 6'b111111, 6, 0, 1);

    // 4b: both ports release the same busy slot
    do_reset();
    drive(1, 3'd1, 0, 3'd0, 0, 3'd0, 0);
    tick(); state("b1", 6'b111101, 5, 0, 0);
    drive(0, 3'd0, 1, 3'd1, 1, 3'd1, 0);
    tick(); state("dup", 6'b111111, 6, 0, 1);

    // 4c: out-of-range release
    do_reset();
    drive(0, 3'd0, 0, 3'd0, 1, 3'd6, 0);
    tick(); state("rel6", 6'b111111, 6, 0, 1);

    // 4d: alloc and release on the same free slot
    do_reset();
    drive(1, 3'd4, 1, 3'd4, 0, 3'd0, 0);
    chk("same.grant", 32'(alloc_grant), 32'd1);
    tick(); state("same", 6'b101111, 5, 0, 1);

    // 5: flush with err already set
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 0);
    tick(); state("f.a0", 6'b101110, 4, 0, 1);
    drive(1, 3'd2, 1, 3'd0, 0, 3'd0, 1);
    chk("fl1.grant", 32'(alloc_grant), 32'd0);
    tick(); state("fl1", 6'b111111, 6, 0, 1);

    // 5b: flush with err clear; illegal release ignored
    do_reset();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 0);
    tick(); state("g.a0", 6'b111110, 5, 0, 0);
    drive(1, 3'd1, 1, 3'd3, 1, 3'd6, 1);
    chk("fl2.grant", 32'(alloc_grant), 32'd0);
    tick(); state("fl2", 6'b111111, 6, 0, 0);

    // 6: async reset mid-cycle
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 0);
    tick();
    drive(1, 3'd1, 0, 3'd0, 0, 3'd0, 0);
    tick();
    drive(0, 3'd0, 0, 3'd0, 1, 3'd7, 0);
    tick(); state("pre", 6'b111100, 4, 0, 1);
    drive(1, 3'd2, 0, 3'd0, 0, 3'd0, 0);
    #1;
    rst = 1'b1;
    #1;
    state("arst", 6'b111111, 6, 0, 0);
    chk("arst.grant", 32'(alloc_grant), 32'd0);
    tick();
    rst = 1'b0;
    drive(1, 3'd3, 0, 3'd0, 0, 3'd0, 0);
    chk("post.grant", 32'(alloc_grant), 32'd1);
    tick(); state("post", 6'b110111, 5, 0, 0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
